// File: rtl/control_unit_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : control_unit_sequencer
//  Purpose  : Hardwired control unit for the ALU datapath. It runs a
//             two-cycle fetch (T0 low byte, T1 high byte). It then decodes
//             IR and issues a one- or two-cycle execute microsequence (T2/T3)
//             that drives the register file, the address register file, the
//             ALU, the IR, memory and the three datapath muxes.
//  Ports    : Clock, Reset (sync, active-high)
//             IR[15:0]            opcode[15:10], Rx[9:8], addr/imm[7:0]
//             ALU_FlagsOut[3:0]   {Z,C,N,O}
//             RF_*  / ARF_*       register-file selects and functions
//             ALU_FunSel, ALU_WF  ALU function and flag write-enable
//             IR_LH, IR_Write     instruction register byte select / write
//             Mem_WR, Mem_CS      memory write (1) and active-low select
//             MuxASel/BSel/CSel   datapath mux selects
//             SC[2:0]             sequence counter (T0..T3)
//             Halted              high while halted
//  Config   : CU_ILLEGAL_HALT_EN - when defined, undefined opcodes halt
//             at the end of T2 instead of executing as a NOP.
//  Revision : 1.0  initial release
// ============================================================================
module control_unit_sequencer (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IR,
    input  logic [3:0]  ALU_FlagsOut,
    output logic [2:0]  RF_OutASel,
    output logic [2:0]  RF_OutBSel,
    output logic [2:0]  RF_FunSel,
    output logic [3:0]  RF_RegSel,
    output logic [3:0]  RF_ScrSel,
    output logic [4:0]  ALU_FunSel,
    output logic        ALU_WF,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [2:0]  ARF_FunSel,
    output logic [2:0]  ARF_RegSel,
    output logic        IR_LH,
    output logic        IR_Write,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic [2:0]  SC,
    output logic        Halted
);

    // Sequence counter steps
    localparam logic [2:0] c_T0 = 3'd0;
    localparam logic [2:0] c_T1 = 3'd1;
    localparam logic [2:0] c_T2 = 3'd2;
    localparam logic [2:0] c_T3 = 3'd3;

    // Opcodes
    localparam logic [5:0] c_OP_BRA = 6'h00;
    localparam logic [5:0] c_OP_BNE = 6'h01;
    localparam logic [5:0] c_OP_BEQ = 6'h02;
    localparam logic [5:0] c_OP_IMM = 6'h03;
    localparam logic [5:0] c_OP_LD  = 6'h04;
    localparam logic [5:0] c_OP_ST  = 6'h05;
    localparam logic [5:0] c_OP_INC = 6'h06;
    localparam logic [5:0] c_OP_DEC = 6'h07;
    localparam logic [5:0] c_OP_HLT = 6'h3F;

    // Register-file function codes
    localparam logic [2:0] c_FUN_DEC   = 3'b000;
    localparam logic [2:0] c_FUN_INC   = 3'b001;
    localparam logic [2:0] c_FUN_LOAD  = 3'b010;
    localparam logic [2:0] c_FUN_CLEAR = 3'b011;

    localparam logic [4:0] c_ALU_PASS_A = 5'b10000;
    localparam logic [1:0] c_MUX_MEM    = 2'b10;
    localparam logic [1:0] c_MUX_IMM    = 2'b11;
    localparam logic [1:0] c_ARF_PC     = 2'b00;
    localparam logic [1:0] c_ARF_AR     = 2'b10;
    localparam logic [2:0] c_SEL_PC     = 3'b100;
    localparam logic [2:0] c_SEL_AR     = 3'b010;

    logic [2:0] r_sc;
    logic       r_halted;

    logic [5:0] w_op;
    logic [1:0] w_rx;
    logic [3:0] w_rx_onehot;
    logic       w_z;
    logic       w_taken;
    logic       w_two_step;
    logic       w_defined;
    logic       w_enter_halt;
    logic       w_unused;

    assign w_op        = IR[15:10];
    assign w_rx        = IR[9:8];
    // Rx=00 selects R1, which sits in the MSB of the one-hot select
    assign w_rx_onehot = 4'b1000 >> w_rx;
    assign w_z         = ALU_FlagsOut[3];

    assign w_taken = (w_op == c_OP_BRA)
                   | ((w_op == c_OP_BNE) & ~w_z)
                   | ((w_op == c_OP_BEQ) &  w_z);

    assign w_two_step = (w_op == c_OP_LD) | (w_op == c_OP_ST)
                      | (w_op == c_OP_INC) | (w_op == c_OP_DEC);

    assign w_defined = (w_op <= c_OP_DEC) | (w_op == c_OP_HLT);

`ifdef CU_ILLEGAL_HALT_EN
    assign w_enter_halt = (w_op == c_OP_HLT) | ~w_defined;
`else
    assign w_enter_halt = (w_op == c_OP_HLT);
`endif

    // Address/immediate byte and C/N/O flags feed the datapath directly,
    // not the sequencer.
    assign w_unused = ^{IR[7:0], ALU_FlagsOut[2:0], w_defined};

    assign SC     = r_sc;
    assign Halted = r_halted;

    // Sequence counter and halt state
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_sc     <= c_T0;
            r_halted <= 1'b0;
        end else if (r_halted) begin
            r_sc <= c_T0;
        end else begin
            case (r_sc)
                c_T0: r_sc <= c_T1;
                c_T1: r_sc <= c_T2;
                c_T2: begin
                    if (w_enter_halt) begin
                        r_halted <= 1'b1;
                        r_sc     <= c_T0;
                    end else if (w_two_step) begin
                        r_sc <= c_T3;
                    end else begin
                        r_sc <= c_T0;
                    end
                end
                default: r_sc <= c_T0;
            endcase
        end
    end

    // Control word decode. Reset overrides everything so a T3 store that
    // coincides with Reset never asserts Mem_CS/Mem_WR.
    always_comb begin
        RF_OutASel  = 3'b000;
        RF_OutBSel  = 3'b000;
        RF_FunSel   = 3'b000;
        RF_RegSel   = 4'b0000;
        RF_ScrSel   = 4'b0000;
        ALU_FunSel  = 5'b00000;
        ALU_WF      = 1'b0;
        ARF_OutCSel = 2'b00;
        ARF_OutDSel = 2'b00;
        ARF_FunSel  = 3'b000;
        ARF_RegSel  = 3'b000;
        IR_LH       = 1'b0;
        IR_Write    = 1'b0;
        Mem_WR      = 1'b0;
        Mem_CS      = 1'b1;
        MuxASel     = 2'b00;
        MuxBSel     = 2'b00;
        MuxCSel     = 1'b0;

        if (Reset) begin
            ARF_RegSel = 3'b111;
            ARF_FunSel = c_FUN_CLEAR;
            RF_RegSel  = 4'b1111;
            RF_ScrSel  = 4'b1111;
            RF_FunSel  = c_FUN_CLEAR;
        end else if (!r_halted) begin
            case (r_sc)
                c_T0, c_T1: begin
                    // Fetch one byte from M[PC] into IR and bump PC
                    ARF_OutDSel = c_ARF_PC;
                    Mem_CS      = 1'b0;
                    IR_Write    = 1'b1;
                    IR_LH       = (r_sc == c_T1);
                    ARF_RegSel  = c_SEL_PC;
                    ARF_FunSel  = c_FUN_INC;
                end
                c_T2: begin
                    case (w_op)
                        c_OP_BRA, c_OP_BNE, c_OP_BEQ: begin
                            if (w_taken) begin
                                MuxBSel    = c_MUX_IMM;
                                ARF_RegSel = c_SEL_PC;
                                ARF_FunSel = c_FUN_LOAD;
                            end
                        end
                        c_OP_IMM: begin
                            MuxASel   = c_MUX_IMM;
                            RF_RegSel = w_rx_onehot;
                            RF_FunSel = c_FUN_LOAD;
                        end
                        c_OP_LD, c_OP_ST: begin
                            MuxBSel    = c_MUX_IMM;
                            ARF_RegSel = c_SEL_AR;
                            ARF_FunSel = c_FUN_LOAD;
                        end
                        c_OP_INC: begin
                            RF_RegSel = w_rx_onehot;
                            RF_FunSel = c_FUN_INC;
                        end
                        c_OP_DEC: begin
                            RF_RegSel = w_rx_onehot;
                            RF_FunSel = c_FUN_DEC;
                        end
                        default: ;
                    endcase
                end
                c_T3: begin
                    case (w_op)
                        c_OP_LD: begin
                            ARF_OutDSel = c_ARF_AR;
                            Mem_CS      = 1'b0;
                            MuxASel     = c_MUX_MEM;
                            RF_RegSel   = w_rx_onehot;
                            RF_FunSel   = c_FUN_LOAD;
                        end
                        c_OP_ST: begin
                            ARF_OutDSel = c_ARF_AR;
                            RF_OutASel  = {1'b0, w_rx};
                            ALU_FunSel  = c_ALU_PASS_A;
                            MuxCSel     = 1'b0;
                            Mem_CS      = 1'b0;
                            Mem_WR      = 1'b1;
                        end
                        c_OP_INC, c_OP_DEC: begin
                            // Pass the updated Rx through the ALU so Z/N track it
                            RF_OutASel = {1'b0, w_rx};
                            ALU_FunSel = c_ALU_PASS_A;
                            ALU_WF     = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/control_unit_sequencer.md
# control_unit_sequencer

Hardwired control unit that drives every control input of the ALU datapath system: register file, address register file, ALU, instruction register, memory and the three datapath muxes. It sequences a two-cycle instruction fetch, then decodes the 16-bit instruction word and issues a 1–2 cycle execute microsequence. It consumes the instruction register contents and the ALU flags, which closes the fetch/decode/execute loop around the datapath.

## Interface
- No parameters.
- Clock  in  1  rising-edge clock; the only clock.
- Reset  in  1  synchronous, active-high reset.
- IR  in  16  instruction word from the instruction register: [15:10] opcode, [9:8] Rx index (00=R1 … 11=R4), [7:0] address/immediate.
- ALU_FlagsOut  in  4  ALU flags: [3]=Z, [2]=C, [1]=N, [0]=O.
- RF_OutASel, RF_OutBSel, RF_FunSel  out  3 each  RF read selects and function.
- RF_RegSel, RF_ScrSel  out  4 each  one-hot active-high; RegSel[3]=R1 … [0]=R4.
- ALU_FunSel  out  5;  ALU_WF  out  1.
- ARF_OutCSel, ARF_OutDSel  out  2 each; 00=PC, 10=AR.
- ARF_FunSel  out  3;  ARF_RegSel  out  3  one-hot active-high: [2]=PC, [1]=AR, [0]=SP.
- IR_LH, IR_Write, Mem_WR, Mem_CS  out  1 each. Mem_CS is active-low. Mem_WR: 1=write.
- MuxASel, MuxBSel  out  2 each;  MuxCSel  out  1.
- SC  out  3  sequence counter T0..T3, for debug and verification.
- Halted  out  1  high in HALT.

## Operation
- Encodings: RF/ARF FunSel 000=dec, 001=inc, 010=load, 011=clear. ALU_FunSel 5'b10000=pass A. Mux code 10=MemOut, 11=IR[7:0] zero-extended.
- Idle control word: all RegSel/ScrSel=0, IR_Write=0, Mem_CS=1, Mem_WR=0, ALU_WF=0, all other selects 0. Any field not listed in a step below holds its idle value.
- T0: ARF_OutDSel=00, Mem_CS=0, Mem_WR=0, IR_Write=1, IR_LH=0, ARF_RegSel=100 with inc.
- T1: same as T0 with IR_LH=1.
- T2/T3, by opcode:
  - 0x00 BRA, 0x01 BNE (taken if Z=0), 0x02 BEQ (taken if Z=1). T2: if taken, MuxBSel=11, ARF_RegSel=100, load. Not taken issues the idle word.
  - 0x03 IMM. T2: MuxASel=11, RF_RegSel=onehot(Rx), load.
  - 0x04 LD. T2: AR ← IR[7:0] (MuxBSel=11, ARF_RegSel=010, load). T3: ARF_OutDSel=10, Mem_CS=0, Mem_WR=0, MuxASel=10, Rx load.
  - 0x05 ST. T2: AR ← IR[7:0]. T3: ARF_OutDSel=10, RF_OutASel=Rx, ALU_FunSel=10000, MuxCSel=0, Mem_CS=0, Mem_WR=1.
  - 0x06 INC / 0x07 DEC. T2: Rx inc/dec. T3: RF_OutASel=Rx, ALU_FunSel=10000, ALU_WF=1, so Z/N reflect the new Rx.
  - 0x3F HLT: enter HALT.
  - Other opcodes: T2 issues the idle word (NOP), unless the configuration macro below is defined.
- Last step of every instruction: SC returns to 0.
- HALT: idle word every cycle, SC=0, Halted=1. Only Reset leaves HALT.
- Reset cycle:
  - SC←0, Halted←0.
  - Outputs: ARF_RegSel=111, RF_RegSel=1111, RF_ScrSel=1111, both FunSel=011 (clear all registers), Mem_CS=1, IR_Write=0.
  - Reset mid-instruction abandons it; a T3 store coinciding with Reset is suppressed.

## Timing
- Outputs are combinational from SC, the HALT state, IR, flags and Reset. SC and HALT are the only state.
- IR is valid from T2, written at the T0 and T1 edges. After fetch, PC = old PC + 2.
- Latency: branch/IMM/NOP = 3 cycles, LD/ST/INC/DEC = 4 cycles.
- Branch condition samples ALU_FlagsOut during T2, i.e. flags latched by the most recent WF=1 edge.
- Memory read is combinational; a write commits at the T3 rising edge.
- First fetch from address 0x0000 starts in the cycle after Reset deasserts.

## Configuration
- CU_ILLEGAL_HALT_EN:
  - Defined: undefined opcodes enter HALT at the end of T2.
  - Undefined: they execute as a 3-cycle NOP.

## Test plan
- Reset held 2 cycles, then released: reset cycles drive ARF_RegSel=111, FunSel=011, Mem_CS=1; afterwards SC sequences 0,1,2,0; the first T0 shows ARF_OutDSel=00, IR_Write=1, IR_LH=0.
- IR=0x0C5A (IMM R1,0x5A): T2 gives MuxASel=11, RF_RegSel=1000, RF_FunSel=010; next cycle SC=0.
- IR=0x1620 (ST R3,0x20): T2 AR load with MuxBSel=11; T3 gives RF_OutASel=010, Mem_WR=1, Mem_CS=0, ARF_OutDSel=10; SC=3 then 0.
- IR=0x0410 (BNE 0x10) with Z=1: no ARF write in T2. Repeat with Z=0: ARF_RegSel=100, FunSel=010, MuxBSel=11.
- IR=0x1C00 (DEC R1): T2 RF_FunSel=000, RF_RegSel=1000; T3 ALU_WF=1, ALU_FunSel=10000. Reset asserted at T3 instead: clear word issued, SC=0 next.
- IR=0xFC00 (HLT): Halted=1 from next cycle with the idle word held 10 cycles. IR=0x2000 gives a NOP, or HALT with CU_ILLEGAL_HALT_EN defined.
